// File: rtl/audio_pkg.sv
// Shared types and constants for the audio capture path.
// Register map, control word layout and receive FSM states.
package audio_pkg;

  localparam int SAMPLE_W_DEF   = 16;
  localparam int FIFO_DEPTH_DEF = 32;
  localparam int IRQ_THRESH_DEF = 16;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  typedef logic [SAMPLE_W_DEF-1:0] sample_t;

  typedef struct packed {
    logic [1:0] chan_sel;
    logic       irq_en;
    logic       enable;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{chan_sel: 2'b11, irq_en: 1'b0, enable: 1'b0};

  typedef enum logic [2:0] {IDLE, SYNC, SKIP, SHIFT, PUSH} rx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO; a push while full is accepted only alongside a pop.
// Zero-latency head (rd_dat shows the oldest entry); count/full/empty update the clk after push/pop.
module sample_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign rd_dat = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_dat;
    end
    // Pointers are power-of-two wide, so plain increment wraps.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/i2s_adc_capture.sv
// I2S ADC receiver: deserialises codec samples into a FIFO read over an Avalon slave.
// Push 1 clk after the LSB bclk rise; full FIFO drops samples and sets sticky ovf; readdata 1-clk latency.
module i2s_adc_capture
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int IRQ_THRESH = IRQ_THRESH_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        aud_bclk,
  input  logic        aud_adclrck,
  input  logic        aud_adcdat,
  input  logic        chipselect,
  input  logic        address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W = $clog2(SAMPLE_W);

  // Synchroniser bit order is {bclk, lrck, dat}.
  logic [2:0]          sync0_q, sync0_d, sync1_q, sync1_d;
  logic                bclk_prev_q, bclk_prev_d, lrck_prev_q, lrck_prev_d;
  logic                bclk_s, lrck_s, dat_s, bclk_rise, lrck_edge;

  rx_state_t           state_q, state_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
  logic                chan_q, chan_d;
  logic                push;

  ctrl_t               ctrl_q, ctrl_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         readdata_q, readdata_d;
  logic                irq_q, irq_d;

  logic                rd_data_req, rd_stat_req, ctrl_wr, clr_ovf, pop, overflow, head_chan;
  logic [5:0]          cnt_sat;
  logic [15:0]         status;
  logic [SAMPLE_W:0]   fifo_rd_dat;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty;
  logic                wdat_unused;

  assign wdat_unused = ^writedata[15:5];

  always_comb begin
    sync0_d     = {aud_bclk, aud_adclrck, aud_adcdat};
    sync1_d     = sync0_q;
    bclk_prev_d = sync1_q[2];
    lrck_prev_d = sync1_q[1];
  end

  assign bclk_s    = sync1_q[2];
  assign lrck_s    = sync1_q[1];
  assign dat_s     = sync1_q[0];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lrck_edge = lrck_s ^ lrck_prev_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    chan_d   = chan_q;
    push     = 1'b0;
    if (!ctrl_q.enable) begin
      state_d  = IDLE;
      shreg_d  = '0;
      bitcnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (lrck_edge) begin
            chan_d  = lrck_s;
            state_d = SKIP;
          end
        end
        // The first rise after a frame-clock change is the I2S one-bit delay slot.
        SKIP: begin
          if (lrck_edge) begin
            chan_d = lrck_s;
          end else if (bclk_rise) begin
            bitcnt_d = '0;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (lrck_edge) begin
            chan_d   = lrck_s;
            shreg_d  = '0;
            bitcnt_d = '0;
            state_d  = SKIP;
          end else if (bclk_rise) begin
            shreg_d = {shreg_q[SAMPLE_W-2:0], dat_s};
            if (bitcnt_q == BIT_W'(SAMPLE_W - 1)) begin
              state_d = PUSH;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
        PUSH: begin
          push    = ctrl_q.chan_sel[chan_q];
          state_d = SYNC;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  sample_fifo #(
    .WIDTH (SAMPLE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wr_dat ({chan_q, shreg_q}),
    .rd_dat (fifo_rd_dat),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    rd_data_req = chipselect & read & (address == ADDR_DATA);
    rd_stat_req = chipselect & read & (address == ADDR_CTRL);
    ctrl_wr     = chipselect & write & (address == ADDR_CTRL);
    clr_ovf     = ctrl_wr & writedata[4];
    pop         = rd_data_req & ~fifo_empty;
    overflow    = push & fifo_full & ~pop;
    head_chan   = ~fifo_empty & fifo_rd_dat[SAMPLE_W];
    cnt_sat     = (32'(fifo_count) > 63) ? 6'd63 : 6'(fifo_count);
    status      = {ctrl_q.chan_sel, ctrl_q.irq_en, ctrl_q.enable, head_chan, ovf_q,
                   fifo_full, fifo_empty, 2'b00, cnt_sat};

    readdata_d = readdata_q;
    if (rd_data_req) begin
      readdata_d = fifo_empty ? 16'h0000 : 16'(fifo_rd_dat[SAMPLE_W-1:0]);
    end else if (rd_stat_req) begin
      readdata_d = status;
    end

    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d.enable   = writedata[0];
      ctrl_d.irq_en   = writedata[1];
      ctrl_d.chan_sel = writedata[3:2];
    end

    // A fresh overflow beats a coincident clear.
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;

    irq_d = ctrl_q.irq_en & ((32'(fifo_count) >= IRQ_THRESH) | ovf_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync0_q     <= '0;
      sync1_q     <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      chan_q      <= 1'b0;
      ctrl_q      <= CTRL_RESET;
      ovf_q       <= 1'b0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync0_q     <= sync0_d;
      sync1_q     <= sync1_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_prev_q <= lrck_prev_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      chan_q      <= chan_d;
      ctrl_q      <= ctrl_d;
      ovf_q       <= ovf_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
